// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with RV32M-style MUL/MULH/MULHSU/MULHU result selection.
// Optional build macro SEQ_MUL_EARLY_EXIT_EN ends the add loop once the multiplier runs out of set bits.
module seq_multiplier #(
  parameter int N = 5,
  localparam int W = 1 << N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  state_t           state_reg, state_next;
  logic [W-1:0]     mcand_reg;
  logic [W-1:0]     mplier_reg;
  logic [2*W-1:0]   acc_reg;
  logic [N-1:0]     count_reg;
  logic             sign_reg;
  logic [1:0]       op_reg;
  logic [W-1:0]     result_reg;

  logic             accept;
  logic             a_signed, b_signed;
  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [2*W-1:0]   addend;
  logic [2*W-1:0]   acc_sum;
  logic [W-1:0]     mplier_shift;
  logic             last_iter;
  logic [2*W-1:0]   acc_final;
  logic [W-1:0]     result_next;

  // MUL is taken as signed x signed; the low word is the same for any signedness.
  always_comb begin
    a_signed = (op != OP_MULHU);
    b_signed = (op == OP_MUL) || (op == OP_MULH);
    a_neg    = a_signed & a[W-1];
    b_neg    = b_signed & b[W-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
  end

  assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // One partial product per CALC cycle, weighted by the iteration count.
  always_comb begin
    addend       = '0;
    if (mplier_reg[0])
      addend = {{W{1'b0}}, mcand_reg} << count_reg;
    acc_sum      = acc_reg + addend;
    mplier_shift = mplier_reg >> 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    last_iter    = (count_reg == N'(W - 1)) || (mplier_shift == '0);
`else
    last_iter    = (count_reg == N'(W - 1));
`endif
  end

  always_comb begin
    acc_final   = sign_reg ? (~acc_reg + 1'b1) : acc_reg;
    result_next = (op_reg == OP_MUL) ? acc_final[W-1:0] : acc_final[2*W-1:W];
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept)
          state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter)
          state_next = S_NEG;
      end
      S_NEG: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = accept ? S_CALC : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      sign_reg   <= 1'b0;
      op_reg     <= OP_MUL;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            acc_reg    <= '0;
            count_reg  <= '0;
            sign_reg   <= a_neg ^ b_neg;
            op_reg     <= op;
          end
        end
        S_CALC: begin
          acc_reg    <= acc_sum;
          mplier_reg <= mplier_shift;
          count_reg  <= count_reg + 1'b1;
        end
        S_NEG: begin
          acc_reg    <= acc_final;
          result_reg <= result_next;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 5; operand width W = 2**N bits, matching the prefix adder width convention.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  operation: 00 MUL (low word), 01 MULH (signed x signed, high word), 10 MULHSU (signed a x unsigned b, high word), 11 MULHU (unsigned x unsigned, high word).
REQ-006 SHALL have ports a, b  input  W each  multiplicand and multiplier, captured on the start edge.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port result  output  W  selected product word; held until the next accepted start or reset.

Function
REQ-010 SHALL implement the FSM IDLE -> CALC -> NEG -> DONE -> IDLE.
REQ-011 IDLE/DONE, start=1: SHALL capture |a|, |b| and op, store the product sign (XOR of operand signs, per op signedness), clear the 2W-bit accumulator and the iteration counter, and go to CALC.
REQ-012 IDLE, start=0: SHALL stay in IDLE. DONE, start=0: SHALL go to IDLE.
REQ-013 Each CALC edge SHALL add the multiplicand, shifted by the iteration count, into the 2W-bit accumulator when the multiplier LSB is 1, shift the multiplier right by one, and increment the counter.
REQ-014 CALC SHALL go to NEG after the edge that completes iteration W (counter reaches W-1), subject to REQ-025.
REQ-015 NEG SHALL two's-complement the 2W-bit accumulator when the stored sign is 1, select the low word (MUL) or high word (others) into result, then go to DONE.
REQ-016 busy SHALL be 1 in CALC and NEG and 0 in IDLE and DONE. done SHALL be 1 only in DONE.
REQ-017 With k CALC iterations, done SHALL be high in the cycle after the (k+2)th rising edge counted from the edge that sampled start; W=32 with no early exit gives k=32, so done follows the 34th edge.
REQ-018 start while busy=1 SHALL be ignored, with no effect on state, operands or result.
REQ-019 start asserted in DONE SHALL be accepted; done still pulses for exactly one cycle.
REQ-020 Signed most-negative operand (0x8000_0000 for W=32) SHALL produce the correct magnitude 2**(W-1), handled as unsigned.
REQ-021 result SHALL be bit-exact to RV32M semantics for all op encodings.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, accumulator=0 and counter=0, from any state.
REQ-023 Reset during CALC or NEG SHALL abort the operation; no done pulse SHALL follow.
REQ-024 reset SHALL take priority over start on the same edge.

Configuration
REQ-025 Macro SEQ_MUL_EARLY_EXIT_EN, when defined: CALC SHALL also exit to NEG after any edge on which the shifted multiplier becomes zero, so k = max(1, index of highest set bit of |b| + 1).
REQ-026 Without SEQ_MUL_EARLY_EXIT_EN: k SHALL always be W. Results SHALL be identical in both builds; only latency differs.

Verification
REQ-027 MUL a=7, b=6 -> result=0x0000_002A, one done pulse; no early exit: done follows edge 34 after start.
REQ-028 MULHU a=b=0xFFFF_FFFF -> result=0xFFFF_FFFE. MUL with the same operands -> result=0x0000_0001.
REQ-029 MULHSU a=0xFFFF_FFFE (-2), b=3 -> result=0xFFFF_FFFF. MULH a=b=0x8000_0000 -> result=0x4000_0000.
REQ-030 Second start pulse with a=1, b=1 at edge 5 of a busy MUL 7x6 -> ignored; result still 0x2A; exactly one done pulse.
REQ-031 reset pulse at edge 10 of a busy operation -> next cycle busy=0, done=0, result=0; no done pulse for 40 cycles.
REQ-032 SEQ_MUL_EARLY_EXIT_EN defined: b=0 -> done follows edge 3 after start, result=0. b=3 -> done follows edge 4. 200 random operand/op pairs checked against a reference model in both builds.
